mem_responder: RTL and testbench

//   Memory-side responder for the multi-cycle CPU's load/store and fetch port.

---
 rtl/mem_responder.sv | 107 ++++++++++
 tb/tb_mem_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder: IDLE accepts, WAIT counts WAIT_CYCLES, RESP holds result.
// Response valid WAIT_CYCLES+1 cycles after accept; req_ready low outside IDLE, response held until rsp_ready.
module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    Reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  wr_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [LANES-1:0]      be_q;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  err;
  logic                  access;
  logic                  commit;

  assign idx    = addr_q[ADDR_WIDTH+1:2];
  assign err    = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
  assign access = (state == S_WAIT) && (cnt == 4'd0);
  // Only a clean write in its final wait cycle touches the array, so a reset in WAIT drops it.
  assign commit = access && wr_q && !err;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            wr_q      <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            cnt       <= WAIT_INIT;
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_rdata <= (!err && !wr_q) ? mem[idx] : '0;
            rsp_err   <= err;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, word/byte R/W, errors, back-pressure, reset mid-op.
module tb_mem_responder;

  logic        CLK;
  logic        Reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests;
  int fails;

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full transaction; hold = cycles rsp_ready stays low while the response is checked for stability.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e, input int hold);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_data"}, rsp_rdata, exp_d);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_vld"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_data"}, rsp_rdata, exp_d);
      check({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_e));
      check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_done_vld"}, 32'(rsp_valid), 32'd0);
    check({tag, "_done_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_done_keep"}, rsp_rdata, exp_d);
    check({tag, "_done_rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    Reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b0;

    // Reset held for 5 cycles.
    repeat (5) tick();
    check("rst_vld", 32'(rsp_valid), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_data", rsp_rdata, 32'd0);
    check("rst_rdy", 32'(req_ready), 32'd0);
    Reset_n = 1'b1;
    tick();
    check("rst_rdy_after", 32'(req_ready), 32'd1);

    // Word write and read-back.
    do_req("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    do_req("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

    // Single byte lane 2.
    do_req("wrlane", 1'b1, 32'h10, 32'h00AA0000, 4'b0100, 32'h0, 1'b0, 0);
    do_req("rdlane", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAABEEF, 1'b0, 0);

    // Empty byte mask changes nothing.
    do_req("wrbe0", 1'b1, 32'h10, 32'h11111111, 4'b0000, 32'h0, 1'b0, 0);
    do_req("rdbe0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAABEEF, 1'b0, 0);

    // Errors: misaligned read, out-of-range write that would alias word 0.
    do_req("wr0", 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 0);
    do_req("rdmis", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    do_req("wroor", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
    do_req("rd0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 0);

    // Back-pressure: response held 4 cycles.
    do_req("bp", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAABEEF, 1'b0, 4);

    // Reset during WAIT drops the pending write.
    do_req("wr20", 1'b1, 32'h20, 32'hCAFE0020, 4'hF, 32'h0, 1'b0, 0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    tick();
    req_valid = 1'b0;
    check("midop_inwait", 32'(req_ready), 32'd0);
    tick();
    Reset_n = 1'b0;
    #1;
    check("midop_rst_vld", 32'(rsp_valid), 32'd0);
    check("midop_rst_rdy", 32'(req_ready), 32'd0);
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
    check("midop_rdy", 32'(req_ready), 32'd1);
    do_req("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE0020, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
